// File: rtl/guess_round_tracker.sv
// Scoring stage for the guessing game: compares each confirmed guess against the
// target and tracks the round, incorrect-guess count and per-round countdown timer.
module guess_round_tracker #(
  parameter int unsigned TIMER_BASE  = 30,
  parameter int unsigned FINAL_ROUND = 10
) (
  input  logic        clk,
  input  logic        restart,
  input  logic        tick_1hz,
  input  logic        confirm_btn,
  input  logic [11:0] guess,
  input  logic [11:0] target,
  input  logic [1:0]  win_or_lose,
  output logic [3:0]  round,
  output logic [2:0]  incorrect_guesses,
  output logic [6:0]  timer,
  output logic        guess_ok,
  output logic        guess_bad,
  output logic        new_target
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [3:0] FINAL_R = 4'(FINAL_ROUND);
  localparam logic [7:0] BASE_8  = 8'(TIMER_BASE);

  state_t      state_q, state_d;
  logic        btn_q, btn_d;
  logic        rise_q, rise_d;
  logic [11:0] guess_q, guess_d;
  logic [3:0]  round_q, round_d;
  logic [2:0]  inc_q, inc_d;
  logic [6:0]  timer_q, timer_d;
  logic        ok_q, ok_d;
  logic        bad_q, bad_d;
  logic        nt_q, nt_d;

  logic        playing;
  logic        match;
  logic [3:0]  round_next;

  function automatic logic [1:0] digits_of(input logic [3:0] r);
    if (r <= 4'd3)      return 2'd1;
    else if (r <= 4'd6) return 2'd2;
    else                return 2'd3;
  endfunction

  function automatic logic [11:0] mask_of(input logic [3:0] r);
    case (digits_of(r))
      2'd1:    return 12'h00F;
      2'd2:    return 12'h0FF;
      default: return 12'hFFF;
    endcase
  endfunction

  // Product is formed at 8 bits and truncated; TIMER_BASE <= 42 keeps it in range.
  function automatic logic [6:0] reload_of(input logic [3:0] r);
    logic [7:0] prod;
    prod = BASE_8 * {6'd0, digits_of(r)};
    return prod[6:0];
  endfunction

  assign playing    = (win_or_lose == 2'b11);
  assign match      = ((guess_q & mask_of(round_q)) == (target & mask_of(round_q)));
  assign round_next = (round_q >= FINAL_R) ? FINAL_R : round_q + 4'd1;

  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    btn_d   = confirm_btn;
    rise_d  = confirm_btn & ~btn_q;
    guess_d = guess_q;
    round_d = round_q;
    inc_d   = inc_q;
    timer_d = timer_q;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    nt_d    = 1'b0;

    if (state_q != HALT && tick_1hz && timer_q != 7'd0)
      timer_d = timer_q - 7'd1;

    case (state_q)
      PLAY: begin
        if (!playing) begin
          state_d = HALT;
          timer_d = timer_q;
        end else if (rise_q && timer_q != 7'd0) begin
          guess_d = guess;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Presses during this cycle are deliberately dropped: rise_q is not looked at.
        if (match) begin
          ok_d    = 1'b1;
          nt_d    = 1'b1;
          round_d = round_next;
          timer_d = reload_of(round_next);
          if (round_next == 4'd4 || round_next == 4'd7)
            inc_d = 3'd0;
        end else begin
          bad_d = 1'b1;
          if (inc_q != 3'd7)
            inc_d = inc_q + 3'd1;
        end
        state_d = playing ? PLAY : HALT;
      end
      default: begin
        state_d = HALT;
        timer_d = timer_q;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (restart) begin
      state_q <= PLAY;
      btn_q   <= 1'b0;
      rise_q  <= 1'b0;
      guess_q <= 12'h000;
      round_q <= 4'd1;
      inc_q   <= 3'd0;
      timer_q <= reload_of(4'd1);
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
      nt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      rise_q  <= rise_d;
      guess_q <= guess_d;
      round_q <= round_d;
      inc_q   <= inc_d;
      timer_q <= timer_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      nt_q    <= nt_d;
    end
  end

  assign round             = round_q;
  assign incorrect_guesses = inc_q;
  assign timer             = timer_q;
  assign guess_ok          = ok_q;
  assign guess_bad         = bad_q;
  assign new_target        = nt_q;

endmodule

// File: tb/tb_guess_round_tracker.sv
// Directed bench for guess_round_tracker: expected compare results are queued as
// presses are issued and a monitor pops them whenever a guess pulse appears.
module tb_guess_round_tracker;

  logic        clk = 1'b0;
  logic        restart = 1'b1;
  logic        tick_1hz = 1'b0;
  logic        confirm_btn = 1'b0;
  logic [11:0] guess = 12'h000;
  logic [11:0] target = 12'h000;
  logic [1:0]  win_or_lose = 2'b11;
  logic [3:0]  round;
  logic [2:0]  incorrect_guesses;
  logic [6:0]  timer;
  logic        guess_ok;
  logic        guess_bad;
  logic        new_target;

  typedef struct {
    bit ok;
    int rnd;
    int inc;
    int tmr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  guess_round_tracker #(.TIMER_BASE(30), .FINAL_ROUND(10)) dut (
    .clk               (clk),
    .restart           (restart),
    .tick_1hz          (tick_1hz),
    .confirm_btn       (confirm_btn),
    .guess             (guess),
    .target            (target),
    .win_or_lose       (win_or_lose),
    .round             (round),
    .incorrect_guesses (incorrect_guesses),
    .timer             (timer),
    .guess_ok          (guess_ok),
    .guess_bad         (guess_bad),
    .new_target        (new_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit ok, input int r, input int i, input int t);
    exp_t e;
    e.ok = ok; e.rnd = r; e.inc = i; e.tmr = t;
    return e;
  endfunction

  task automatic check_state(input string tag, input int r, input int i, input int t);
    check({tag, "_round"}, round, r);
    check({tag, "_incorrect"}, incorrect_guesses, i);
    check({tag, "_timer"}, timer, t);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  // Press confirm for 'hold' cycles (>=3). The compare happens on the third
  // rising edge after the press; tick_on_check raises tick_1hz for that edge.
  task automatic press(input logic [11:0] g, input logic [11:0] t, input int hold,
                       input bit tick_on_check, input bit expect_pulse, input exp_t e);
    if (expect_pulse) sb.push_back(e);
    @(negedge clk);
    guess = g; target = t; confirm_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (tick_on_check) tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    repeat (hold - 3) @(negedge clk);
    confirm_btn = 1'b0;
    repeat (6) @(negedge clk);
    if (expect_pulse) begin
      check("scoreboard_drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (guess_ok || guess_bad) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got ok=%0b bad=%0b, expected no pulse (t=%0t)",
                 guess_ok, guess_bad, $time);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_ok", guess_ok, mon_e.ok);
        check("pulse_bad", guess_bad, !mon_e.ok);
        check("pulse_new_target", new_target, mon_e.ok);
        check("pulse_round", round, mon_e.rnd);
        check("pulse_incorrect", incorrect_guesses, mon_e.inc);
        check("pulse_timer", timer, mon_e.tmr);
      end
    end
  end

  initial begin
    int r_new;
    int d;

    // Reset held for two cycles.
    restart = 1'b1;
    repeat (2) @(negedge clk);
    check_state("reset", 1, 0, 30);
    check("reset_pulses", {guess_ok, guess_bad, new_target}, 0);
    restart = 1'b0;

    // First correct guess, then four wrong guesses in round 2.
    press(12'h005, 12'h005, 3, 1'b0, 1'b1, mk(1, 2, 0, 30));
    for (int k = 1; k <= 4; k++)
      press(12'h001, 12'h002, 3, 1'b0, 1'b1, mk(0, 2, k, 30));
    // One-digit masking: only the ones digit matters.
    press(12'h125, 12'h7A5, 3, 1'b0, 1'b1, mk(1, 3, 4, 30));
    // Entering round 4 clears the level's incorrect count and reloads 60.
    press(12'h009, 12'h009, 3, 1'b0, 1'b1, mk(1, 4, 0, 60));
    // Two-digit compare: 25 vs 35 mismatches.
    press(12'h125, 12'h735, 3, 1'b0, 1'b1, mk(0, 4, 1, 60));
    press(12'h042, 12'h042, 3, 1'b0, 1'b1, mk(1, 5, 1, 60));
    // Hundreds digit ignored in two-digit rounds; tick on the reload cycle is lost.
    press(12'h142, 12'h942, 3, 1'b1, 1'b1, mk(1, 6, 1, 60));
    press(12'h077, 12'h077, 3, 1'b0, 1'b1, mk(1, 7, 0, 90));
    // Three-digit compare now sees the hundreds digit.
    press(12'h123, 12'h923, 3, 1'b0, 1'b1, mk(0, 7, 1, 90));

    // Timer runs down to zero and holds; presses at zero are ignored.
    do_restart();
    for (int k = 0; k < 29; k++) do_tick();
    check("timer_one_left", timer, 1);
    do_tick();
    check("timer_zero", timer, 0);
    do_tick();
    check("timer_hold_zero", timer, 0);
    press(12'h005, 12'h005, 3, 1'b0, 1'b0, mk(0, 0, 0, 0));
    check_state("timer_zero_press", 1, 0, 0);

    // Ten correct guesses from reset: round climbs to 10 and saturates.
    do_restart();
    for (int k = 0; k < 10; k++) begin
      r_new = (k + 2 > 10) ? 10 : k + 2;
      d = (r_new <= 3) ? 1 : (r_new <= 6) ? 2 : 3;
      press(12'h123, 12'h123, 3, 1'b0, 1'b1, mk(1, r_new, 0, 30 * d));
    end

    // Game over: presses and ticks leave everything frozen, even after status returns.
    win_or_lose = 2'b00;
    @(negedge clk);
    press(12'h123, 12'h123, 3, 1'b0, 1'b0, mk(0, 0, 0, 0));
    for (int k = 0; k < 5; k++) do_tick();
    check_state("halt", 10, 0, 90);
    win_or_lose = 2'b11;
    press(12'h123, 12'h123, 3, 1'b0, 1'b0, mk(0, 0, 0, 0));
    do_tick();
    check_state("halt_sticky", 10, 0, 90);

    // Restart landing on the CHECK cycle discards the compare.
    do_restart();
    press(12'h005, 12'h005, 3, 1'b0, 1'b1, mk(1, 2, 0, 30));
    @(negedge clk);
    guess = 12'h006; target = 12'h006; confirm_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    restart = 1'b1; confirm_btn = 1'b0;
    @(negedge clk);
    restart = 1'b0;
    repeat (5) @(negedge clk);
    check_state("restart_in_check", 1, 0, 30);

    // Button held for 20 cycles yields exactly one compare.
    press(12'h005, 12'h005, 20, 1'b0, 1'b1, mk(1, 2, 0, 30));
    check_state("held_button", 2, 0, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/guess_round_tracker.md
Name: guess_round_tracker

Overview:
- Scoring stage that sits directly upstream of the difficulty/game-state FSM.
- Captures each confirmed player guess, compares it with the current target number, and maintains the round number, the incorrect-guess count and the per-round countdown timer.
- The FSM consumes these three values and returns its game status.
- Requests a new target from the random-number source after every correct guess.

Parameters:
- TIMER_BASE, 30, seconds per round per active digit; must be ≤ 42 so that 3*TIMER_BASE fits in 7 bits.
- FINAL_ROUND, 10, round value at which the game is won; round saturates here.

Ports:
- clk  in  1  system clock
- restart  in  1  synchronous reset, active-high
- tick_1hz  in  1  one-cycle strobe, once per second
- confirm_btn  in  1  debounced confirm button, active-high level
- guess  in  12  player guess, 3 BCD digits, [3:0] = ones
- target  in  12  current target, 3 BCD digits
- win_or_lose  in  2  FSM game status: 2'b11 = playing, anything else = game over/won
- round  out  4  current round, 1..FINAL_ROUND
- incorrect_guesses  out  3  wrong guesses in the current difficulty level
- timer  out  7  seconds remaining in the current round
- guess_ok  out  1  one-cycle pulse, correct guess
- guess_bad  out  1  one-cycle pulse, wrong guess
- new_target  out  1  one-cycle pulse requesting the next target

Behaviour:
Reset:
- Sampled on the clk edge; restart=1 overrides all other inputs.
- round=1, incorrect_guesses=0, timer=TIMER_BASE, all pulses 0, state=PLAY, edge-detect register=0.
- Reset mid-CHECK discards the pending compare.

Active digits:
- Derived internally from round, not from the FSM: rounds 1-3 → 1 digit, 4-6 → 2 digits, 7+ → 3 digits.
- Compare only the active low digits; inactive upper digits are masked on both guess and target.

Confirm edge:
- Registered rising-edge detect on confirm_btn gives confirm_rise.

States:
- PLAY: on confirm_rise, if win_or_lose==2'b11 and timer!=0, capture guess into guess_q and go to CHECK. Otherwise ignore the press.
- CHECK: exactly one cycle; compare masked guess_q against masked target; return to PLAY.
  - Match: guess_ok=1, new_target=1, round=round+1 (saturate at FINAL_ROUND).
    - If the new round is 4 or 7, incorrect_guesses=0.
    - Reload timer = TIMER_BASE * active digits of the new round.
  - Mismatch: guess_bad=1, incorrect_guesses+1 (saturate at 7); round and timer unchanged.
  - confirm_rise during CHECK is dropped.
- HALT: entered from PLAY or CHECK when win_or_lose!=2'b11.
  - All counters freeze; no pulses are generated.
  - Exit only via restart.
  - A CHECK cycle that coincides with win_or_lose!=2'b11 completes its update, then goes to HALT.

Latency:
- confirm_btn rising at edge E → confirm_rise at E+1 → CHECK at E+2 → outputs visible after E+2.
- Pulses are high for exactly one cycle.

Timer:
- On tick_1hz, in PLAY or CHECK with timer>0, decrement by 1.
- Holds at 0; never wraps.
- A reload and a tick in the same cycle: reload wins, no decrement.

Widths and saturation:
- Timer reload product is computed at 8 bits and truncated to 7.
- round never exceeds FINAL_ROUND.

Outputs:
- All outputs registered; no combinational path from input to output.

Test Plan:
- Reset, then correct guess: restart=1 for 2 cycles → round=1, timer=30, incorrect=0. guess=target=12'h005, press confirm → after 3 cycles guess_ok and new_target pulse once, round=2, timer=30.
- Masking: round=1, guess=12'h125, target=12'h7A5 → match (only ones digit compared). round=4, guess=12'h125, target=12'h735 → guess_bad, incorrect=1.
- Wrong guesses and level clear: 4 wrong guesses in round 2 → incorrect=4. Correct guesses through round 3→4 → incorrect=0, timer=60. Through 6→7 → timer=90.
- Timer: 30 tick_1hz strobes with no guess → timer=0 and holds. A further confirm is ignored: no pulse, round unchanged. A tick on the same cycle as a reload → timer=60, not 59.
- Win/halt: with win_or_lose=2'b00 forced, confirm presses and ticks leave all outputs constant. Nine correct guesses from reset → round=10 and holds at 10.
- Reset mid-operation and held button: assert restart on the CHECK cycle → no pulse, round=1. Hold confirm_btn high for 20 cycles → exactly one compare.
